gate_truth_table_scanner: RTL and testbench

Sequencer that exercises any 2-input combinational gate (NAND, NOR, UDP primitives) in hardware. On a start pulse it drives all four input combinations in order, waits a programmable settle time, samples the gate output, assembles a 4-bit truth table and compares it with an expected pattern. It sits between a gate instance and a status/LED or test-bench observer, replacing hand-written stimulus sequences for gate bring-up.

---
 rtl/gate_scan_pkg.sv | 25 ++
 rtl/gate_truth_table_scanner_if.sv | 49 ++++
 rtl/settle_timer.sv | 36 +++
 rtl/gate_truth_table_scanner.sv | 154 +++++++++++++++
 tb/tb_gate_truth_table_scanner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_scan_pkg.sv
// gate_scan_pkg
//   Shared definitions for the gate truth-table scanner:
//   - scan_state_t : scanner FSM states (IDLE, DRIVE, SETTLE, SAMPLE, DONE)
//   - TT_*         : reference truth tables for common 2-input gates,
//                    bit index = {A,B}
//   - SETTLE_W     : width of the settle counter
package gate_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } scan_state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/gate_truth_table_scanner_if.sv
// gate_scan_if
//   Signal bundle between the scanner, the gate under test and the
//   status observer.
//     start     : scan request (observer -> scanner)
//     Y         : gate output (gate -> scanner)
//     A, B      : gate inputs (scanner -> gate)
//     busy      : scan in progress
//     done      : one-cycle pulse, table_o/pass valid
//     table_o   : captured truth table, bit {A,B} = Y
//     pass      : table_o matches the expected pattern
//     err_count : failed-scan counter (only with GATE_SCAN_ERRCNT_EN)
//   Modports: slave = scanner side, master = observer/stimulus side.
interface gate_scan_if;

  logic       start;
  logic       Y;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic [3:0] table_o;
  logic       pass;
`ifdef GATE_SCAN_ERRCNT_EN
  logic [7:0] err_count;
`endif

`ifdef GATE_SCAN_ERRCNT_EN
  modport slave (
    input  start, Y,
    output A, B, busy, done, table_o, pass, err_count
  );

  modport master (
    output start, Y,
    input  A, B, busy, done, table_o, pass, err_count
  );
`else
  modport slave (
    input  start, Y,
    output A, B, busy, done, table_o, pass
  );

  modport master (
    output start, Y,
    input  A, B, busy, done, table_o, pass
  );
`endif

endinterface

// File: rtl/settle_timer.sv
// settle_timer
//   Loadable down-counter used to hold the gate inputs stable before
//   sampling. load has priority over dec; the counter stops at zero.
//     clk, rst  : clock, asynchronous active-high reset
//     load      : load counter with load_val
//     load_val  : reload value
//     dec       : decrement by one (ignored at zero)
//     expired   : counter is at its last count (== 1)
module settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Flag the final cycle so the controller leaves SETTLE after exactly
  // load_val cycles.
  assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/gate_truth_table_scanner.sv
// gate_truth_table_scanner
//   Drives all four input combinations of a 2-input gate (00,01,10,11),
//   waits SETTLE_CYCLES after each change, samples Y, builds a 4-bit
//   truth table and compares it with EXPECTED.
//   Parameters:
//     SETTLE_CYCLES : cycles waited after each input change (1..15)
//     EXPECTED      : expected truth table, bit {A,B} (default NAND)
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset
//     bus : gate_scan_if.slave (start, Y in; A, B, busy, done,
//           table_o, pass out)
//   Build option:
//     GATE_SCAN_ERRCNT_EN : adds bus.err_count, a saturating count of
//                           completed scans that failed (cleared by rst).
module gate_truth_table_scanner
  import gate_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = TT_NAND
) (
  input logic        clk,
  input logic        rst,
  gate_scan_if.slave bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);

  scan_state_t state;
  scan_state_t state_nxt;

  logic [1:0] idx;
  logic [3:0] table_q;
  logic [3:0] table_next;
  logic       pass_q;
  logic       a_q;
  logic       b_q;

  logic       accept;
  logic       settle_load;
  logic       settle_dec;
  logic       settle_expired;
  logic       sample_en;
  logic       busy_c;
  logic       done_c;

  settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load),
    .load_val (SETTLE_VAL),
    .dec      (settle_dec),
    .expired  (settle_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_DRIVE;
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_expired) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (idx == 2'd3) ? ST_DONE : ST_DRIVE;
      // A start held high re-enters DRIVE straight from DONE, so
      // back-to-back scans start the cycle after the done pulse.
      ST_DONE:   state_nxt = bus.start ? ST_DRIVE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept      = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    sample_en   = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    unique case (state)
      ST_IDLE:   accept = bus.start;
      ST_DRIVE:  begin busy_c = 1'b1; settle_load = 1'b1; end
      ST_SETTLE: begin busy_c = 1'b1; settle_dec  = 1'b1; end
      ST_SAMPLE: begin busy_c = 1'b1; sample_en   = 1'b1; end
      ST_DONE:   begin busy_c = 1'b1; done_c = 1'b1; accept = bus.start; end
      default:   ;
    endcase
  end

  always_comb begin
    table_next      = table_q;
    table_next[idx] = bus.Y;
  end

  // Datapath: A/B are updated on the edge that enters DRIVE, so they are
  // stable through DRIVE and all SETTLE cycles before the sampling edge.
  // pass is resolved on the final sampling edge so it is valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      table_q <= '0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      table_q    <= '0;
      pass_q     <= 1'b0;
      {a_q, b_q} <= 2'b00;
    end else if (sample_en) begin
      table_q <= table_next;
      if (idx == 2'd3) begin
        // Case equality: an X/Z sample never matches, so pass reads 0.
        pass_q     <= (table_next === EXPECTED);
        {a_q, b_q} <= 2'b00;
      end else begin
        idx        <= idx + 2'd1;
        {a_q, b_q} <= idx + 2'd1;
      end
    end
  end

`ifdef GATE_SCAN_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (done_c && !pass_q && (err_q != '1)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.err_count = err_q;
`endif

  assign bus.A       = a_q;
  assign bus.B       = b_q;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.table_o = table_q;
  assign bus.pass    = pass_q;

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// tb_gate_truth_table_scanner
//   Self-checking bench for gate_truth_table_scanner. Three instances:
//   default parameters, SETTLE_CYCLES=1 and SETTLE_CYCLES=15, each with a
//   behavioural gate model selected by gsel. Expected scan results are
//   queued when start is driven and checked when done is seen.
module tb_gate_truth_table_scanner;
  import gate_scan_pkg::*;

  typedef enum int unsigned {G_NAND, G_NOR, G_AND, G_OR, G_XOR} gate_e;

  typedef struct {
    gate_e      g;
    logic [3:0] tbl;
    logic       p;
  } vec_t;

  typedef struct {
    logic [3:0]  tbl;
    logic        p;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  gate_e       gsel = G_NAND;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned ndone_d = 0;
  int unsigned done1_cyc = 0;
  int unsigned done15_cyc = 0;
`ifdef GATE_SCAN_ERRCNT_EN
  int unsigned exp_err = 0;
`endif

  exp_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_fn(gate_e g, logic a, logic b);
    case (g)
      G_NAND:  return ~(a & b);
      G_NOR:   return ~(a | b);
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_XOR:   return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  gate_scan_if bus_d ();
  gate_scan_if bus_1 ();
  gate_scan_if bus_15 ();

  assign bus_d.Y  = gate_fn(gsel, bus_d.A, bus_d.B);
  assign bus_1.Y  = gate_fn(gsel, bus_1.A, bus_1.B);
  assign bus_15.Y = gate_fn(gsel, bus_15.A, bus_15.B);

  gate_truth_table_scanner dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  gate_truth_table_scanner #(
    .SETTLE_CYCLES (1)
  ) dut_1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_1)
  );

  gate_truth_table_scanner #(
    .SETTLE_CYCLES (15)
  ) dut_15 (
    .clk (clk),
    .rst (rst),
    .bus (bus_15)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock step; outputs are sampled on the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus_d.done === 1'b1) begin
      ndone_d++;
      chk("done_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("table_o", bus_d.table_o, e.tbl);
        chk("pass", bus_d.pass, e.p);
`ifdef GATE_SCAN_ERRCNT_EN
        if (!e.p) exp_err++;
`endif
      end
    end
    if (bus_1.done === 1'b1 && done1_cyc == 0) done1_cyc = cyc;
    if (bus_15.done === 1'b1 && done15_cyc == 0) done15_cyc = cyc;
  endtask

  // Start is accepted on the next rising edge; done follows 16 edges later.
  task automatic start_pulse(bit push, logic [3:0] tbl, logic p);
    bus_d.start = 1'b1;
    if (push) sb.push_back('{tbl, p, cyc + 17});
    tick();
    bus_d.start = 1'b0;
  endtask

  task automatic wait_drain(int unsigned budget);
    int unsigned k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int unsigned n0;
    int unsigned c;
    int unsigned k;

    vecs[0] = '{G_NAND, 4'b0111, 1'b1};
    vecs[1] = '{G_NOR,  4'b0001, 1'b0};
    vecs[2] = '{G_AND,  4'b1000, 1'b0};
    vecs[3] = '{G_OR,   4'b1110, 1'b0};
    vecs[4] = '{G_XOR,  4'b0110, 1'b0};

    bus_d.start  = 1'b0;
    bus_1.start  = 1'b0;
    bus_15.start = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_A", bus_d.A, 0);
    chk("rst_B", bus_d.B, 0);
    chk("rst_busy", bus_d.busy, 0);
    chk("rst_done", bus_d.done, 0);
    chk("rst_table", bus_d.table_o, 0);
    chk("rst_pass", bus_d.pass, 0);
    chk("rst_busy_s1", bus_1.busy, 0);
    chk("rst_busy_s15", bus_15.busy, 0);
`ifdef GATE_SCAN_ERRCNT_EN
    chk("rst_err_count", bus_d.err_count, 0);
`endif
    rst = 1'b0;
    tick();

    // NAND scan: A/B walk 00,01,10,11, one combination every 4 cycles
    gsel = G_NAND;
    start_pulse(1'b1, 4'b0111, 1'b1);
    chk("busy_after_accept", bus_d.busy, 1);
    chk("ab_seq_0", {bus_d.A, bus_d.B}, 0);
    for (int unsigned i = 1; i < 4; i++) begin
      repeat (4) tick();
      chk("ab_seq", {bus_d.A, bus_d.B}, i);
    end
    wait_drain(40);
    tick();
    chk("busy_after_done", bus_d.busy, 0);
    chk("ab_idle", {bus_d.A, bus_d.B}, 0);

    // Table-driven gate sweep with the default (NAND) expectation
    for (int unsigned i = 0; i < 5; i++) begin
      gsel = vecs[i].g;
      start_pulse(1'b1, vecs[i].tbl, vecs[i].p);
      wait_drain(40);
      repeat (3) tick();
      chk("table_hold", bus_d.table_o, vecs[i].tbl);
      chk("pass_hold", bus_d.pass, vecs[i].p);
    end
`ifdef GATE_SCAN_ERRCNT_EN
    chk("err_count", bus_d.err_count, exp_err);
`endif

    // start re-pulsed mid-scan is ignored
    gsel = G_NAND;
    n0 = ndone_d;
    start_pulse(1'b1, 4'b0111, 1'b1);
    repeat (3) tick();
    bus_d.start = 1'b1;
    tick();
    bus_d.start = 1'b0;
    wait_drain(40);
    repeat (20) tick();
    chk("single_done", ndone_d - n0, 1);

    // Reset at cycle 9 of a scan aborts it without a done pulse
    start_pulse(1'b0, 4'b0000, 1'b0);
    repeat (8) tick();
    chk("table_partial", bus_d.table_o, 4'b0011);
    n0 = ndone_d;
    rst = 1'b1;
    #1;
    chk("abort_A", bus_d.A, 0);
    chk("abort_B", bus_d.B, 0);
    chk("abort_busy", bus_d.busy, 0);
    chk("abort_table", bus_d.table_o, 0);
    chk("abort_pass", bus_d.pass, 0);
`ifdef GATE_SCAN_ERRCNT_EN
    exp_err = 0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("no_done_after_abort", ndone_d, n0);
    start_pulse(1'b1, 4'b0111, 1'b1);
    wait_drain(40);

    // start held high for 40 cycles: scans run back-to-back
    c = cyc;
    bus_d.start = 1'b1;
    sb.push_back('{4'b0111, 1'b1, c + 17});
    sb.push_back('{4'b0111, 1'b1, c + 34});
    sb.push_back('{4'b0111, 1'b1, c + 51});
    repeat (40) tick();
    bus_d.start = 1'b0;
    wait_drain(40);

    // SETTLE_CYCLES = 1 and 15: done at +12 and +68 after accept
    gsel = G_NAND;
    c = cyc;
    done1_cyc = 0;
    done15_cyc = 0;
    bus_1.start  = 1'b1;
    bus_15.start = 1'b1;
    tick();
    bus_1.start  = 1'b0;
    bus_15.start = 1'b0;
    k = 0;
    while ((done1_cyc == 0 || done15_cyc == 0) && k < 100) begin
      tick();
      k++;
    end
    chk("done_cycle_s1", done1_cyc, c + 13);
    chk("done_cycle_s15", done15_cyc, c + 69);
    chk("table_s1", bus_1.table_o, 4'b0111);
    chk("pass_s1", bus_1.pass, 1);
    chk("table_s15", bus_15.table_o, 4'b0111);
    chk("pass_s15", bus_15.pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
